// File: rtl/fetch_pkg.sv
// Shared types and defaults for the picoMIPS instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned PSIZE_DEFAULT = 6;
   localparam int unsigned ISIZE_DEFAULT = 24;

   typedef logic [ISIZE_DEFAULT-1:0] instr_t;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      DONE
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order instruction buffer. Entry 0 is always the head, so the
// head word stays put until it is popped and, once the buffer empties, the
// last word presented remains on the output.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int Isize = ISIZE_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [Isize-1:0] din,
   output logic [Isize-1:0] head,
   output logic [1:0]       count
);

   logic [Isize-1:0] mem0_q, mem0_d;
   logic [Isize-1:0] mem1_q, mem1_d;
   logic [1:0]       count_q, count_d;

   assign head  = mem0_q;
   assign count = count_q;

   // Next entry contents and occupancy; a pop shifts entry 1 into the head.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
      mem0_d  = mem0_q;
      mem1_d  = mem1_q;
      count_d = count_q;
      if (flush) begin
         count_d = 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_q == 2'd0) mem0_d = din;
               else                 mem1_d = din;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               if (count_q == 2'd2) mem0_d = mem1_q;
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd2) begin
                  mem0_d = mem1_q;
                  mem1_d = din;
               end else begin
                  mem0_d = din;
               end
            end
            default: ;
         endcase
      end
   end

   // Buffer registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (reset) begin
         // NOTE: both storage entries are reset, not just the count, because the head word must read as zero out of reset instead of X.
         mem0_q  <= '0;
         mem1_q  <= '0;
         count_q <= 2'd0;
      end else begin
         mem0_q  <= mem0_d;
         mem1_q  <= mem1_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// picoMIPS instruction-fetch stage: issues PCout to a 1-cycle synchronous ROM,
// buffers returned words in fetch_fifo and hands them to decode over a
// valid/ready handshake. An address is issued only when a buffer slot is
// guaranteed for it, so pc advances exactly when there is room.
// Build option FETCH_WRAP_STOP_EN: after issuing the top address the stage
// drains its buffer and parks in DONE with fetch_done high instead of wrapping.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int Psize = PSIZE_DEFAULT,
   parameter int Isize = ISIZE_DEFAULT,
   parameter int Depth = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [Psize-1:0] PCout,
   output logic             PCincr,
   output logic [Psize-1:0] rom_addr,
   input  logic [Isize-1:0] rom_data,
   input  logic             flush,
   output logic [Isize-1:0] instr,
   output logic             instr_valid,
   input  logic             instr_ready,
   output logic             fetch_done
);

   localparam logic [2:0] DEPTH_L = 3'(Depth);

   fetch_state_t state_q, state_d;
   logic         inflight_q, inflight_d;
   logic [1:0]   fifo_count;
   logic [2:0]   credit_used;
   logic         pop;
   logic         push;
   logic         issue;

   assign rom_addr    = PCout;
   assign instr_valid = (fifo_count != 2'd0);
   assign pop         = instr_valid & instr_ready;
   // The word read last cycle lands now unless a flush is discarding it.
   assign push        = inflight_q & ~flush;

   // Slots that will still be occupied or claimed after this cycle's pop.
   assign credit_used = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue       = (state_q == RUN) & ~flush & ~reset & (credit_used < DEPTH_L);
   assign PCincr      = issue;
   assign inflight_d  = issue;

   fetch_fifo #(
      .Isize (Isize)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (rom_data),
      .head  (instr),
      .count (fifo_count)
   );

   // Fetch state: flush always returns to RUN; the drain/stop path exists only with the option.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = RUN;
      end
`ifdef FETCH_WRAP_STOP_EN
      else begin
         case (state_q)
            RUN:     if (issue && (PCout == '1)) state_d = DRAIN;
            DRAIN:   if ((fifo_count == 2'd0) && !inflight_q) state_d = DONE;
            default: ;
         endcase
      end
`endif
   end

`ifdef FETCH_WRAP_STOP_EN
   assign fetch_done = (state_q == DONE);
`else
   assign fetch_done = 1'b0;
`endif

   // State and in-flight read tracking; reset drops any outstanding ROM read.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
      end
   end

endmodule
